// File: rtl/imm_encoder_pkg.sv
// ============================================================================
//  Module   : imm_encoder_pkg
//  Purpose  : ExtOp codes, per-format immediate masks and a range helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package imm_encoder_pkg;

    typedef enum logic [2:0] {
        EXT_I = 3'b000,
        EXT_U = 3'b001,
        EXT_S = 3'b010,
        EXT_B = 3'b011,
        EXT_J = 3'b100
    } ext_op_e;

    localparam logic [31:0] C_MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] C_MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] C_MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] C_MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] C_MASK_J = 32'hFFFF_F000;

    // True when v[31:lo] are all copies of the same bit (value fits as signed).
    function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] lo);
        logic [31:0] s;
        s = $unsigned($signed(v) >>> lo);
        return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_encoder_pack.sv
// ============================================================================
//  Module   : imm_pack
//  Purpose  : Combinational packing of an immediate into its format's fields.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_base,
    output logic [31:0] o_instr,
    output logic        o_err
);

    always_comb begin
        o_instr = i_base;
        o_err   = 1'b1;
        case (i_fmt)
            EXT_I: begin
                o_instr = (i_base & ~C_MASK_I) | {i_imm[11:0], 20'h0_0000};
                o_err   = !fits_signed(i_imm, 5'd11);
            end
            EXT_U: begin
                o_instr = (i_base & ~C_MASK_U) | {i_imm[31:12], 12'h000};
                o_err   = (i_imm[11:0] != 12'h000);
            end
            EXT_S: begin
                o_instr = (i_base & ~C_MASK_S)
                        | {i_imm[11:5], 13'h0000, i_imm[4:0], 7'h00};
                o_err   = !fits_signed(i_imm, 5'd11);
            end
            EXT_B: begin
                o_instr = (i_base & ~C_MASK_B)
                        | {i_imm[12], i_imm[10:5], 13'h0000, i_imm[4:1], i_imm[11], 7'h00};
                o_err   = i_imm[0] || !fits_signed(i_imm, 5'd12);
            end
            EXT_J: begin
                o_instr = (i_base & ~C_MASK_J)
                        | {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'h000};
                o_err   = i_imm[0] || !fits_signed(i_imm, 5'd20);
            end
            default: begin
                // Illegal format: pass the base word through untouched.
                o_instr = i_base;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
//  Module   : imm_encoder
//  Purpose  : Registered valid/ready immediate encoder with error counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] err_count
);

    logic [31:0] w_instr;
    logic        w_err;
    logic        w_accept;

    logic        r_valid;
    logic [31:0] r_instr;
    logic        r_err;
    logic [15:0] r_err_count;

    imm_pack u_pack (
        .i_fmt   (in_fmt),
        .i_imm   (in_imm),
        .i_base  (in_base),
        .o_instr (w_instr),
        .o_err   (w_err)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_instr     <= 32'h0000_0000;
            r_err       <= 1'b0;
            r_err_count <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_instr <= w_instr;
                r_err   <= w_err;
                if (w_err && (r_err_count != 16'hFFFF)) begin
                    r_err_count <= r_err_count + 16'h0001;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_err   = r_err;
    assign err_count = r_err_count;

endmodule

`default_nettype wire
